// File: rtl/nic_out_vc_ctrl.sv
// nic_out_vc_ctrl: output VC states, downstream credits, VC ownership and RR flit scheduler.
// Define VC_CTRL_ERR_CHECK_EN to add a sticky err_o flag for ignored grants and bad credits.
module nic_out_vc_ctrl #(
  parameter int N_OF_REQUEST      = 4,
  parameter int N_OF_VC           = 2,
  parameter int N_BITS_OF_REQUEST = (N_OF_REQUEST > 1) ? $clog2(N_OF_REQUEST) : 1,
  parameter int N_BITS_OF_VC      = (N_OF_VC > 1) ? $clog2(N_OF_VC) : 1,
  parameter int CREDIT_DEPTH      = 4,
  parameter int N_BITS_CREDIT     = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_OF_REQUEST-1:0]         g_va_vn_i,
  input  logic [N_OF_REQUEST*N_OF_VC-1:0] g_vc_i,
  output logic [N_OF_VC-1:0]              vc_free_o,
  input  logic [N_OF_REQUEST-1:0]         flit_valid_i,
  input  logic [N_OF_REQUEST-1:0]         flit_tail_i,
  output logic                            flit_send_o,
  output logic [N_OF_REQUEST-1:0]         sel_o,
  output logic [N_BITS_OF_VC-1:0]         vc_id_o,
  input  logic [N_OF_VC-1:0]              credit_i
`ifdef VC_CTRL_ERR_CHECK_EN
  ,
  output logic                            err_o
`endif
);

  localparam logic [N_BITS_CREDIT-1:0] FULL = N_BITS_CREDIT'(CREDIT_DEPTH);
  localparam logic [N_BITS_CREDIT-1:0] ONE  = N_BITS_CREDIT'(1);

  typedef enum logic [1:0] {VC_FREE, VC_ALLOC, VC_DRAIN} vc_st_e;

  vc_st_e                      st_q   [N_OF_VC];
  vc_st_e                      st_d   [N_OF_VC];
  logic [N_BITS_CREDIT-1:0]    cred_q [N_OF_VC];
  logic [N_BITS_CREDIT-1:0]    cred_d [N_OF_VC];
  logic [N_BITS_OF_VC-1:0]     idx_q  [N_OF_REQUEST];
  logic [N_BITS_OF_VC-1:0]     idx_d  [N_OF_REQUEST];
  logic [N_OF_REQUEST-1:0]     has_q, has_d;
  logic [N_BITS_OF_REQUEST-1:0] rr_q, rr_d;
  logic [N_OF_REQUEST-1:0]     elig;
  logic [N_BITS_OF_REQUEST-1:0] win;
  logic                        err_ev;

  always_comb begin
    for (int r = 0; r < N_OF_REQUEST; r++) begin
      elig[r] = has_q[r] & flit_valid_i[r] & (cred_q[idx_q[r]] != '0);
    end
    for (int v = 0; v < N_OF_VC; v++) begin
      vc_free_o[v] = (st_q[v] == VC_FREE);
    end
  end

  // Round-robin search starting at rr_q; first eligible request wins.
  always_comb begin
    logic [N_BITS_OF_REQUEST-1:0] j;
    logic found;
    j           = '0;
    found       = 1'b0;
    win         = '0;
    rr_d        = rr_q;
    sel_o       = '0;
    flit_send_o = 1'b0;
    vc_id_o     = '0;
    for (int i = 0; i < N_OF_REQUEST; i++) begin
      j = N_BITS_OF_REQUEST'((int'(rr_q) + i) % N_OF_REQUEST);
      if (!found && elig[j]) begin
        found = 1'b1;
        win   = j;
      end
    end
    if (found) begin
      sel_o[win]  = 1'b1;
      flit_send_o = 1'b1;
      vc_id_o     = idx_q[win];
      rr_d        = N_BITS_OF_REQUEST'((int'(win) + 1) % N_OF_REQUEST);
    end
  end

  always_comb begin
    logic [N_OF_VC-1:0] slice;
    logic [N_OF_VC-1:0] taken;
    logic [N_BITS_OF_VC-1:0] vg;
    logic snd;
    st_d   = st_q;
    cred_d = cred_q;
    has_d  = has_q;
    idx_d  = idx_q;
    err_ev = 1'b0;
    slice  = '0;
    taken  = '0;
    vg     = '0;
    snd    = 1'b0;
    for (int v = 0; v < N_OF_VC; v++) begin
      if (st_q[v] == VC_DRAIN && cred_q[v] == FULL) st_d[v] = VC_FREE;
    end
    if (flit_send_o && flit_tail_i[win]) begin
      has_d[win]       = 1'b0;
      st_d[vc_id_o]    = VC_DRAIN;
    end
    // Lower request index claims a contested VC first.
    for (int r = 0; r < N_OF_REQUEST; r++) begin
      if (g_va_vn_i[r]) begin
        slice = g_vc_i[r*N_OF_VC +: N_OF_VC];
        vg    = '0;
        for (int v = 0; v < N_OF_VC; v++) begin
          if (slice[v]) vg = N_BITS_OF_VC'(v);
        end
        if ($onehot(slice) && !has_q[r] && st_q[vg] == VC_FREE && !taken[vg]) begin
          taken[vg] = 1'b1;
          has_d[r]  = 1'b1;
          idx_d[r]  = vg;
          st_d[vg]  = VC_ALLOC;
        end else begin
          err_ev = 1'b1;
        end
      end
    end
    for (int v = 0; v < N_OF_VC; v++) begin
      snd = flit_send_o && (vc_id_o == N_BITS_OF_VC'(v));
      if (snd && !credit_i[v]) begin
        cred_d[v] = cred_q[v] - ONE;
      end else if (!snd && credit_i[v]) begin
        if (cred_q[v] == FULL) err_ev = 1'b1;
        else cred_d[v] = cred_q[v] + ONE;
      end
      if (credit_i[v] && st_q[v] == VC_FREE) err_ev = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_OF_VC; v++) begin
        st_q[v]   <= VC_FREE;
        cred_q[v] <= FULL;
      end
      for (int r = 0; r < N_OF_REQUEST; r++) begin
        idx_q[r] <= '0;
      end
      has_q <= '0;
      rr_q  <= '0;
    end else begin
      st_q   <= st_d;
      cred_q <= cred_d;
      idx_q  <= idx_d;
      has_q  <= has_d;
      rr_q   <= rr_d;
    end
  end

`ifdef VC_CTRL_ERR_CHECK_EN
  logic err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_q | err_ev;
  end
  assign err_o = err_q;
`else
  logic unused_err;
  assign unused_err = err_ev;
`endif

endmodule

// File: tb/tb_nic_out_vc_ctrl.sv
// tb_nic_out_vc_ctrl: directed and random checks of nic_out_vc_ctrl
// against a behavioural VC/credit model.
module tb_nic_out_vc_ctrl;
  localparam int NR = 4;
  localparam int NV = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [NR-1:0] gva, fv, ft;
  logic [NR*NV-1:0] gvc;
  logic [NV-1:0] crin;
  logic [NV-1:0] vc_free;
  logic send;
  logic [NR-1:0] sel;
  logic [0:0] vc_id;
`ifdef VC_CTRL_ERR_CHECK_EN
  logic err;
`endif

  int checks = 0;
  int errors = 0;

  int m_st [NV];
  int m_cr [NV];
  bit m_has [NR];
  int m_vof [NR];
  int m_rr;
  bit m_err;
  int win;
  logic exp_send;
  logic [NR-1:0] exp_sel;
  logic [0:0] exp_vc;
  logic [NV-1:0] exp_free;

  always #5 clk = ~clk;

  nic_out_vc_ctrl dut (
    .clk(clk),
    .rst(rst),
    .g_va_vn_i(gva),
    .g_vc_i(gvc),
    .vc_free_o(vc_free),
    .flit_valid_i(fv),
    .flit_tail_i(ft),
    .flit_send_o(send),
    .sel_o(sel),
    .vc_id_o(vc_id),
    .credit_i(crin)
`ifdef VC_CTRL_ERR_CHECK_EN
    ,
    .err_o(err)
`endif
  );

  function automatic void m_reset();
    for (int v = 0; v < NV; v++) begin
      m_st[v] = 0;
      m_cr[v] = DEPTH;
    end
    for (int r = 0; r < NR; r++) begin
      m_has[r] = 0;
      m_vof[r] = 0;
    end
    m_rr = 0;
    m_err = 0;
  endfunction

  function automatic void m_outs();
    int j;
    win = -1;
    for (int i = 0; i < NR; i++) begin
      j = (m_rr + i) % NR;
      if (win < 0 && m_has[j] && fv[j] && m_cr[m_vof[j]] > 0) win = j;
    end
    exp_send = (win >= 0);
    exp_sel = (win >= 0) ? NR'(1 << win) : '0;
    exp_vc = (win >= 0) ? 1'(m_vof[win]) : 1'b0;
    for (int v = 0; v < NV; v++) exp_free[v] = (m_st[v] == 0);
  endfunction

  function automatic void m_step();
    int nst [NV];
    bit nhas [NR];
    bit claimed [NV];
    int ones, vs, svc, c;
    m_outs();
    nst = m_st;
    nhas = m_has;
    svc = (win >= 0) ? m_vof[win] : -1;
    for (int v = 0; v < NV; v++) begin
      claimed[v] = 0;
      if (m_st[v] == 2 && m_cr[v] == DEPTH) nst[v] = 0;
    end
    if (win >= 0 && ft[win]) begin
      nhas[win] = 0;
      nst[svc] = 2;
    end
    for (int r = 0; r < NR; r++) begin
      if (gva[r]) begin
        ones = 0;
        vs = 0;
        for (int k = 0; k < NV; k++) begin
          if (gvc[r*NV+k]) begin
            ones++;
            vs = k;
          end
        end
        if (ones == 1 && !m_has[r] && m_st[vs] == 0 && !claimed[vs]) begin
          claimed[vs] = 1;
          nhas[r] = 1;
          m_vof[r] = vs;
          nst[vs] = 1;
        end else m_err = 1;
      end
    end
    for (int v = 0; v < NV; v++) begin
      c = m_cr[v] - ((svc == v) ? 1 : 0) + (crin[v] ? 1 : 0);
      if (c > DEPTH) begin
        c = DEPTH;
        m_err = 1;
      end
      if (crin[v] && m_st[v] == 0) m_err = 1;
      m_cr[v] = c;
    end
    m_st = nst;
    m_has = nhas;
    if (win >= 0) m_rr = (win + 1) % NR;
  endfunction

  task automatic idle();
    gva = '0; gvc = '0; fv = '0; ft = '0; crin = '0;
  endtask

  task automatic settle();
    #1;
    m_outs();
  endtask

  task automatic adv();
    @(posedge clk);
    m_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b0;
    m_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({vc_free, sel, send, vc_id} !== {2'b11, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset got free=%b sel=%b send=%b vc=%0d want 11/0000/0/0",
               vc_free, sel, send, vc_id);
    end
    @(negedge clk);
    rst = 1'b1;
    settle();
    checks++;
    if ({send, vc_free} !== {exp_send, exp_free}) begin
      errors++;
      $display("FAIL reset_rel got send=%b free=%b want %b/%b", send, vc_free, exp_send, exp_free);
    end
    adv();
  endtask

  task automatic test_single_packet();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      gva = (c == 0) ? 4'b0010 : '0;
      gvc = (c == 0) ? 8'h04 : '0;
      fv = (c >= 1 && c <= 3) ? 4'b0010 : '0;
      ft = (c == 3) ? 4'b0010 : '0;
      crin = (c >= 5 && c <= 7) ? 2'b01 : '0;
      settle();
      checks++;
      if ({send, sel, vc_id, vc_free} !== {exp_send, exp_sel, exp_vc, exp_free}) begin
        errors++;
        $display("FAIL pkt c%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c,
                 send, sel, vc_id, vc_free, exp_send, exp_sel, exp_vc, exp_free);
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if ({sel, vc_id} !== {4'b0010, 1'b0}) begin
          errors++;
          $display("FAIL pkt_sel c%0d got sel=%b vc=%0d want 0010/0", c, sel, vc_id);
        end
      end
      if (c == 8 || c == 9) begin
        checks++;
        if (vc_free !== ((c == 8) ? 2'b10 : 2'b11)) begin
          errors++;
          $display("FAIL pkt_free c%0d got %b want %b", c, vc_free,
                   (c == 8) ? 2'b10 : 2'b11);
        end
      end
      adv();
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int c = 0; c < 9; c++) begin
      gva = (c == 0) ? 4'b0101 : '0;
      gvc = (c == 0) ? 8'h21 : '0;
      fv = (c >= 1) ? 4'b0101 : '0;
      for (int v = 0; v < NV; v++) crin[v] = (m_cr[v] < DEPTH);
      settle();
      checks++;
      if ({send, sel, vc_id, vc_free} !== {exp_send, exp_sel, exp_vc, exp_free}) begin
        errors++;
        $display("FAIL rr c%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c,
                 send, sel, vc_id, vc_free, exp_send, exp_sel, exp_vc, exp_free);
      end
      if (c >= 1) begin
        checks++;
        if (sel !== ((c % 2) ? 4'b0001 : 4'b0100)) begin
          errors++;
          $display("FAIL rr_alt c%0d got %b want %b", c, sel, (c % 2) ? 4'b0001 : 4'b0100);
        end
      end
      adv();
    end
  endtask

  task automatic test_credit_exhaust();
    int sends = 0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      gva = (c == 0) ? 4'b0100 : '0;
      gvc = (c == 0) ? 8'h20 : '0;
      fv = (c >= 1) ? 4'b0100 : '0;
      crin = (c == 7) ? 2'b10 : '0;
      settle();
      if (send) sends++;
      checks++;
      if ({send, sel, vc_id, vc_free} !== {exp_send, exp_sel, exp_vc, exp_free}) begin
        errors++;
        $display("FAIL cred c%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c,
                 send, sel, vc_id, vc_free, exp_send, exp_sel, exp_vc, exp_free);
      end
      if (c == 7 || c == 8) begin
        checks++;
        if (sel !== ((c == 8) ? 4'b0100 : 4'b0000)) begin
          errors++;
          $display("FAIL cred_sel c%0d got %b want %b", c, sel, (c == 8) ? 4'b0100 : 4'b0000);
        end
      end
      adv();
    end
    checks++;
    if (sends != 5) begin
      errors++;
      $display("FAIL cred_count got %0d want 5", sends);
    end
  endtask

  task automatic test_send_credit_same();
    int sends = 0;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      gva = (c == 0) ? 4'b0001 : (c == 3) ? 4'b1000 : '0;
      gvc = (c == 0) ? 8'h01 : (c == 3) ? 8'h40 : '0;
      fv = (c == 1) ? 4'b0001 : (c >= 2) ? 4'b1001 : '0;
      crin = (c == 1) ? 2'b01 : '0;
      settle();
      if (send) sends++;
      checks++;
      if ({send, sel, vc_id, vc_free} !== {exp_send, exp_sel, exp_vc, exp_free}) begin
        errors++;
        $display("FAIL same c%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c,
                 send, sel, vc_id, vc_free, exp_send, exp_sel, exp_vc, exp_free);
      end
`ifdef VC_CTRL_ERR_CHECK_EN
      checks++;
      if (err !== ((c >= 4) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL same_err c%0d got %b want %b", c, err, (c >= 4) ? 1'b1 : 1'b0);
      end
`endif
      adv();
    end
    checks++;
    if (sends != 5) begin
      errors++;
      $display("FAIL same_count got %0d want 5", sends);
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    for (int c = 0; c < 3; c++) begin
      gva = (c == 0) ? 4'b0010 : '0;
      gvc = (c == 0) ? 8'h08 : '0;
      fv = (c >= 1) ? 4'b0010 : '0;
      settle();
      checks++;
      if ({send, sel, vc_id, vc_free} !== {exp_send, exp_sel, exp_vc, exp_free}) begin
        errors++;
        $display("FAIL mid c%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c,
                 send, sel, vc_id, vc_free, exp_send, exp_sel, exp_vc, exp_free);
      end
      adv();
    end
    #2;
    rst = 1'b0;
    m_reset();
    #1;
    checks++;
    if ({vc_free, sel, send, vc_id} !== {2'b11, 4'b0000, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_rst got free=%b sel=%b send=%b vc=%0d want 11/0000/0/0",
               vc_free, sel, send, vc_id);
    end
    @(negedge clk);
    rst = 1'b1;
    idle();
    adv();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      gva = NR'($urandom & $urandom);
      for (int r = 0; r < NR; r++) begin
        gvc[r*NV +: NV] = ($urandom % 4 != 0) ? NV'(1 << ($urandom % NV)) : NV'($urandom);
      end
      fv = NR'($urandom);
      ft = NR'($urandom & $urandom);
      for (int v = 0; v < NV; v++) begin
        crin[v] = (m_cr[v] < DEPTH && ($urandom % 2 == 1)) || ($urandom % 16 == 0);
      end
      settle();
      checks++;
      if ({send, sel, vc_id, vc_free} !== {exp_send, exp_sel, exp_vc, exp_free}) begin
        errors++;
        $display("FAIL rand c%0d got %b/%b/%0d/%b want %b/%b/%0d/%b", c,
                 send, sel, vc_id, vc_free, exp_send, exp_sel, exp_vc, exp_free);
      end
`ifdef VC_CTRL_ERR_CHECK_EN
      checks++;
      if (err !== m_err) begin
        errors++;
        $display("FAIL rand_err c%0d got %b want %b", c, err, m_err);
      end
`endif
      adv();
    end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_round_robin();
    test_credit_exhaust();
    test_send_credit_same();
    test_reset_mid_packet();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
